// File: rtl/grf_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// grf_hazard_scoreboard
//
// GRF hazard controller for the 5-stage (F/D/E/M/W) pipeline. A shadow copy of
// the pending register writes in E, M and W, each with its remaining Tnew, is
// compared against the D-stage sources and their Tuse. The result drives the
// D-stage stall/bubble and the D/E forwarding mux selects.
//
// Ports
//   clk        pipeline clock, all state updates on the rising edge
//   reset      synchronous active-low reset
//   d_valid    D stage holds a real instruction
//   d_rs/d_rt  D-stage source registers
//   d_tuse_*   cycles until the source is consumed (all-ones = unused)
//   d_we       instruction writes the GRF
//   d_dst      destination register
//   d_tnew     Tnew on entering E
//   stall      freeze PC and F/D, insert a bubble into E
//   fwd_d_*    D operand select: 0 GRF, 1 E result, 2 M result
//   fwd_e_*    E operand select: 0 pipeline register, 1 M result, 2 W result
//   stall_cnt  saturating count of stalled cycles since reset
// -----------------------------------------------------------------------------
module grf_hazard_scoreboard #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned T_W    = 2,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_valid,
   input  logic [ADDR_W-1:0] d_rs,
   input  logic [ADDR_W-1:0] d_rt,
   input  logic [T_W-1:0]    d_tuse_rs,
   input  logic [T_W-1:0]    d_tuse_rt,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_dst,
   input  logic [T_W-1:0]    d_tnew,
   output logic              stall,
   output logic [1:0]        fwd_d_rs,
   output logic [1:0]        fwd_d_rt,
   output logic [1:0]        fwd_e_rs,
   output logic [1:0]        fwd_e_rt,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [T_W-1:0]   TUSE_NONE = {T_W{1'b1}};
   localparam logic [T_W-1:0]   T_ONE     = {{(T_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   // Shadow pipeline entries
   logic              e_valid_q, m_valid_q, w_valid_q;
   logic              e_we_q, m_we_q, w_we_q;
   logic [ADDR_W-1:0] e_dst_q, m_dst_q, w_dst_q;
   logic [T_W-1:0]    e_tnew_q, m_tnew_q, w_tnew_q;
   logic [ADDR_W-1:0] e_rs_q, e_rt_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic e_live, m_live, w_live;
   logic haz_rs, haz_rt, stall_raw;
   logic [1:0] fwd_d_rs_raw, fwd_d_rt_raw, fwd_e_rs_raw, fwd_e_rt_raw;

   function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
      return (t == '0) ? '0 : t - T_ONE;
   endfunction

   // Register 0 is hardwired, so a write to it is never live
   assign e_live = e_valid_q && e_we_q && (e_dst_q != '0);
   assign m_live = m_valid_q && m_we_q && (m_dst_q != '0);
   assign w_live = w_valid_q && w_we_q && (w_dst_q != '0);

   // A source stalls when a live write to it will not be ready by its Tuse.
   // W is never checked: its Tnew is always 0 and the GRF bypasses it.
   always_comb begin
      haz_rs = 1'b0;
      haz_rt = 1'b0;
      if (d_tuse_rs != TUSE_NONE) begin
         haz_rs = (e_live && (e_dst_q == d_rs) && (e_tnew_q > d_tuse_rs)) ||
                  (m_live && (m_dst_q == d_rs) && (m_tnew_q > d_tuse_rs));
      end
      if (d_tuse_rt != TUSE_NONE) begin
         haz_rt = (e_live && (e_dst_q == d_rt) && (e_tnew_q > d_tuse_rt)) ||
                  (m_live && (m_dst_q == d_rt) && (m_tnew_q > d_tuse_rt));
      end
      stall_raw = d_valid && (haz_rs || haz_rt);
   end

   // D forwarding: E is the younger write so it wins over M. A match that is
   // not ready yet yields 0; the stall covers it.
   always_comb begin
      fwd_d_rs_raw = 2'd0;
      if (e_live && (e_dst_q == d_rs)) begin
         fwd_d_rs_raw = (e_tnew_q == '0) ? 2'd1 : 2'd0;
      end else if (m_live && (m_dst_q == d_rs) && (m_tnew_q == '0)) begin
         fwd_d_rs_raw = 2'd2;
      end

      fwd_d_rt_raw = 2'd0;
      if (e_live && (e_dst_q == d_rt)) begin
         fwd_d_rt_raw = (e_tnew_q == '0) ? 2'd1 : 2'd0;
      end else if (m_live && (m_dst_q == d_rt) && (m_tnew_q == '0)) begin
         fwd_d_rt_raw = 2'd2;
      end
   end

   // E forwarding: M over W, only for a valid E entry
   always_comb begin
      fwd_e_rs_raw = 2'd0;
      fwd_e_rt_raw = 2'd0;
      if (e_valid_q) begin
         if (m_live && (m_dst_q == e_rs_q) && (m_tnew_q == '0)) begin
            fwd_e_rs_raw = 2'd1;
         end else if (w_live && (w_dst_q == e_rs_q)) begin
            fwd_e_rs_raw = 2'd2;
         end
         if (m_live && (m_dst_q == e_rt_q) && (m_tnew_q == '0)) begin
            fwd_e_rt_raw = 2'd1;
         end else if (w_live && (w_dst_q == e_rt_q)) begin
            fwd_e_rt_raw = 2'd2;
         end
      end
   end

   // Outputs are forced quiet while reset is asserted
   always_comb begin
      stall     = reset && stall_raw;
      fwd_d_rs  = reset ? fwd_d_rs_raw : 2'd0;
      fwd_d_rt  = reset ? fwd_d_rt_raw : 2'd0;
      fwd_e_rs  = reset ? fwd_e_rs_raw : 2'd0;
      fwd_e_rt  = reset ? fwd_e_rt_raw : 2'd0;
      stall_cnt = stall_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         e_valid_q   <= 1'b0;
         e_we_q      <= 1'b0;
         e_dst_q     <= '0;
         e_tnew_q    <= '0;
         e_rs_q      <= '0;
         e_rt_q      <= '0;
         m_valid_q   <= 1'b0;
         m_we_q      <= 1'b0;
         m_dst_q     <= '0;
         m_tnew_q    <= '0;
         w_valid_q   <= 1'b0;
         w_we_q      <= 1'b0;
         w_dst_q     <= '0;
         w_tnew_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         m_valid_q <= e_valid_q;
         m_we_q    <= e_we_q;
         m_dst_q   <= e_dst_q;
         m_tnew_q  <= tnew_dec(e_tnew_q);
         w_valid_q <= m_valid_q;
         w_we_q    <= m_we_q;
         w_dst_q   <= m_dst_q;
         w_tnew_q  <= tnew_dec(m_tnew_q);
         if (stall_raw) begin
            e_valid_q <= 1'b0;
            e_we_q    <= 1'b0;
            e_dst_q   <= '0;
            e_tnew_q  <= '0;
            e_rs_q    <= '0;
            e_rt_q    <= '0;
            if (stall_cnt_q != CNT_MAX) begin
               stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
         end else begin
            e_valid_q <= d_valid;
            e_we_q    <= d_we;
            e_dst_q   <= d_dst;
            e_tnew_q  <= d_tnew;
            e_rs_q    <= d_rs;
            e_rt_q    <= d_rt;
         end
      end
   end

endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
module tb_grf_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        d_valid;
   logic [4:0]  d_rs, d_rt, d_dst;
   logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
   logic        d_we;
   logic        stall;
   logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
   logic [31:0] stall_cnt;

   int tests  = 0;
   int failed = 0;

   grf_hazard_scoreboard dut (
      .clk       (clk),
      .reset     (reset),
      .d_valid   (d_valid),
      .d_rs      (d_rs),
      .d_rt      (d_rt),
      .d_tuse_rs (d_tuse_rs),
      .d_tuse_rt (d_tuse_rt),
      .d_we      (d_we),
      .d_dst     (d_dst),
      .d_tnew    (d_tnew),
      .stall     (stall),
      .fwd_d_rs  (fwd_d_rs),
      .fwd_d_rt  (fwd_d_rt),
      .fwd_e_rs  (fwd_e_rs),
      .fwd_e_rt  (fwd_e_rt),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] urs, input logic [1:0] urt, input logic we,
                        input logic [4:0] dst, input logic [1:0] tnew);
      d_valid   = v;
      d_rs      = rs;
      d_rt      = rt;
      d_tuse_rs = urs;
      d_tuse_rt = urt;
      d_we      = we;
      d_dst     = dst;
      d_tnew    = tnew;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0);
   endtask

   task automatic flush();
      idle();
      tick();
      tick();
      tick();
   endtask

   initial begin
      reset = 1'b0;
      idle();
      tick();
      tick();
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_fwd_d", {28'd0, fwd_d_rs, fwd_d_rt}, 32'd0);
      chk("rst_fwd_e", {28'd0, fwd_e_rs, fwd_e_rt}, 32'd0);
      chk("rst_cnt", stall_cnt, 32'd0);
      reset = 1'b1;
      #1;

      // 1: load then use
      drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd8, 2'd2);
      chk("t1_issue_stall", {31'd0, stall}, 32'd0);
      tick();
      drive(1'b1, 5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd0);
      chk("t1_stall", {31'd0, stall}, 32'd1);
      tick();
      chk("t1_stall_released", {31'd0, stall}, 32'd0);
      chk("t1_fwd_d_rs", {30'd0, fwd_d_rs}, 32'd0);
      chk("t1_cnt", stall_cnt, 32'd1);
      tick();
      idle();
      chk("t1_fwd_e_rs_w", {30'd0, fwd_e_rs}, 32'd2);
      chk("t1_fwd_e_rt", {30'd0, fwd_e_rt}, 32'd0);
      chk("t1_cnt_hold", stall_cnt, 32'd1);
      flush();

      // 2: ALU then branch
      drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd9, 2'd1);
      tick();
      drive(1'b1, 5'd9, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0);
      chk("t2_stall", {31'd0, stall}, 32'd1);
      tick();
      chk("t2_stall_released", {31'd0, stall}, 32'd0);
      chk("t2_fwd_d_rs_m", {30'd0, fwd_d_rs}, 32'd2);
      chk("t2_fwd_d_rt", {30'd0, fwd_d_rt}, 32'd0);
      chk("t2_cnt", stall_cnt, 32'd2);
      flush();

      // ALU result consumed late in E, forwarded from M
      drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd10, 2'd1);
      tick();
      drive(1'b1, 5'd10, 5'd10, 2'd2, 2'd2, 1'b0, 5'd0, 2'd0);
      chk("e_path_no_stall", {31'd0, stall}, 32'd0);
      chk("e_path_fwd_d_notready", {30'd0, fwd_d_rs}, 32'd0);
      tick();
      idle();
      chk("e_path_fwd_e_rs_m", {30'd0, fwd_e_rs}, 32'd1);
      chk("e_path_fwd_e_rt_m", {30'd0, fwd_e_rt}, 32'd1);
      flush();

      // 3: back-to-back writes to $5, E wins
      drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd5, 2'd0);
      tick();
      tick();
      drive(1'b1, 5'd5, 5'd5, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
      chk("t3_stall", {31'd0, stall}, 32'd0);
      chk("t3_fwd_d_rs_e", {30'd0, fwd_d_rs}, 32'd1);
      chk("t3_fwd_d_rt_e", {30'd0, fwd_d_rt}, 32'd1);
      flush();

      // 4: register zero
      drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd2);
      tick();
      drive(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
      chk("t4_stall", {31'd0, stall}, 32'd0);
      chk("t4_fwd_d_rs", {30'd0, fwd_d_rs}, 32'd0);
      flush();

      // 5: unused source does not stall, used one does
      drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd3, 2'd2);
      tick();
      drive(1'b1, 5'd0, 5'd3, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0);
      chk("t5_unused_rt", {31'd0, stall}, 32'd0);
      drive(1'b1, 5'd0, 5'd3, 2'd3, 2'd0, 1'b0, 5'd0, 2'd0);
      chk("t5_used_rt", {31'd0, stall}, 32'd1);
      drive(1'b1, 5'd0, 5'd3, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0);
      tick();
      chk("t5_cnt", stall_cnt, 32'd2);
      flush();

      // 6: reset mid-stall
      drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd8, 2'd2);
      tick();
      drive(1'b1, 5'd8, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0);
      chk("t6_pre_stall", {31'd0, stall}, 32'd1);
      reset = 1'b0;
      #1;
      chk("t6_rst_stall", {31'd0, stall}, 32'd0);
      chk("t6_rst_fwd", {24'd0, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt}, 32'd0);
      tick();
      reset = 1'b1;
      #1;
      chk("t6_cnt_cleared", stall_cnt, 32'd0);
      chk("t6_no_stall_after", {31'd0, stall}, 32'd0);
      tick();
      chk("t6_cnt_stays", stall_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
